// File: rtl/gb_timer_pkg.sv
// Shared definitions for the DIV/TIMA/TMA/TAC timer: register map, clock-select
// and FSM encodings, and the divider-tap selection helper.
package gb_timer_pkg;

    localparam logic [15:0] DIV_ADDR  = 16'hFF04;
    localparam logic [15:0] TIMA_ADDR = 16'hFF05;
    localparam logic [15:0] TMA_ADDR  = 16'hFF06;
    localparam logic [15:0] TAC_ADDR  = 16'hFF07;

    typedef enum logic [1:0] {
        TAC_4096   = 2'b00,
        TAC_262144 = 2'b01,
        TAC_65536  = 2'b10,
        TAC_16384  = 2'b11
    } tac_clk_sel_t;

    typedef enum logic {
        T_IDLE   = 1'b0,
        T_RELOAD = 1'b1
    } timer_state_t;

    // Divider bit whose falling edge clocks TIMA for the given rate.
    function automatic logic tick_bit(input logic [15:0] cnt, input tac_clk_sel_t sel);
        logic b;
        case (sel)
            TAC_4096:   b = cnt[9];
            TAC_262144: b = cnt[3];
            TAC_65536:  b = cnt[5];
            default:    b = cnt[7];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gb_timer_tick.sv
// Free-running system counter (DIV source) and the TIMA increment strobe,
// taken as the falling edge of the enabled, selected divider tap.
module gb_timer_tick
    import gb_timer_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_div_clr,
    input  logic [2:0] i_tac,
    output logic [7:0] o_div,
    output logic       o_inc_pulse
);

    logic [15:0] r_sys_cnt;
    logic        r_prev_tick;
    logic        w_tick_sig;

    // Gating by TAC enable before edge detection makes DIV clears and TAC
    // writes produce the same spurious increments as the original silicon.
    assign w_tick_sig = i_tac[2] & tick_bit(r_sys_cnt, tac_clk_sel_t'(i_tac[1:0]));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sys_cnt   <= 16'h0000;
            r_prev_tick <= 1'b0;
        end else begin
            r_sys_cnt   <= i_div_clr ? 16'h0000 : r_sys_cnt + 16'h0001;
            r_prev_tick <= w_tick_sig;
        end
    end

    assign o_div       = r_sys_cnt[15:8];
    assign o_inc_pulse = r_prev_tick & ~w_tick_sig;

endmodule

// File: rtl/gb_timer.sv
// Memory-mapped DIV/TIMA/TMA/TAC timer with delayed TMA reload and a sticky
// interrupt request.
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = DIV_ADDR,
    parameter int          RELOAD_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        hit,
    output logic        irq_req,
    input  logic        irq_ack
);

    localparam logic [1:0] OFF_DIV  = 2'(DIV_ADDR  - DIV_ADDR);
    localparam logic [1:0] OFF_TIMA = 2'(TIMA_ADDR - DIV_ADDR);
    localparam logic [1:0] OFF_TMA  = 2'(TMA_ADDR  - DIV_ADDR);
    localparam logic [1:0] OFF_TAC  = 2'(TAC_ADDR  - DIV_ADDR);
    localparam logic [1:0] RL_INIT  = 2'(RELOAD_DELAY - 1);

    logic [7:0]   r_tima, r_tma;
    logic [2:0]   r_tac;
    timer_state_t r_state, w_state_nxt;
    logic [1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]   w_tima_nxt;
    logic         r_irq, w_irq_set;

    logic [15:0]  w_off;
    logic [1:0]   w_sel;
    logic         w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
    logic [7:0]   w_div;
    logic         w_inc;

    // Offset compare handles a base near the top of the address space.
    assign w_off     = addr - BASE_ADDR;
    assign hit       = (w_off < 16'd4);
    assign w_sel     = w_off[1:0];
    assign w_wr_div  = we & hit & (w_sel == OFF_DIV);
    assign w_wr_tima = we & hit & (w_sel == OFF_TIMA);
    assign w_wr_tma  = we & hit & (w_sel == OFF_TMA);
    assign w_wr_tac  = we & hit & (w_sel == OFF_TAC);

    gb_timer_tick u_tick (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_div_clr   (w_wr_div),
        .i_tac       (r_tac),
        .o_div       (w_div),
        .o_inc_pulse (w_inc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tima_nxt  = r_tima;
        w_irq_set   = 1'b0;
        case (r_state)
            T_IDLE: begin
                if (w_wr_tima) begin
                    w_tima_nxt = wdata;
                end else if (w_inc) begin
                    if (r_tima == 8'hFF) begin
                        w_tima_nxt  = 8'h00;
                        w_state_nxt = T_RELOAD;
                        w_cnt_nxt   = RL_INIT;
                    end else begin
                        w_tima_nxt = r_tima + 8'h01;
                    end
                end
            end
            T_RELOAD: begin
                // Final clock commits the reload; a CPU write to TIMA is lost here.
                if (r_cnt == 2'd0) begin
                    w_tima_nxt  = w_wr_tma ? wdata : r_tma;
                    w_irq_set   = 1'b1;
                    w_state_nxt = T_IDLE;
                end else if (w_wr_tima) begin
                    w_tima_nxt  = wdata;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = T_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: w_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tima  <= 8'h00;
            r_tma   <= 8'h00;
            r_tac   <= 3'b000;
            r_state <= T_IDLE;
            r_cnt   <= 2'd0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_tma) r_tma <= wdata;
            if (w_wr_tac) r_tac <= wdata[2:0];
            r_tima  <= w_tima_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_irq_set)    r_irq <= 1'b1;
            else if (irq_ack) r_irq <= 1'b0;
        end
    end

    assign irq_req = r_irq;

    always_comb begin
        rdata = 8'hFF;
        if (hit) begin
            case (w_sel)
                OFF_DIV:  rdata = w_div;
                OFF_TIMA: rdata = r_tima;
                OFF_TMA:  rdata = r_tma;
                default:  rdata = {5'b11111, r_tac};
            endcase
        end
    end

endmodule

// File: tb/tb_gb_timer.sv
// Directed cycle-exact bench for gb_timer with a scoreboard queue of expectations.
`timescale 1ns/1ps
module tb_gb_timer;

    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  rdata;
    logic        hit;
    logic        irq_req;
    logic        irq_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct { string tag; logic [7:0] val; } exp_t;
    exp_t sbq[$];

    gb_timer dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .hit     (hit),
        .irq_req (irq_req),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic ck(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop_ck(input logic [7:0] got);
        exp_t e;
        if (sbq.size() == 0) begin
            ck("sb_underflow", 8'h01, 8'h00);
        end else begin
            e = sbq.pop_front();
            ck(e.tag, got, e.val);
        end
    endtask

    // Each of these consumes exactly one active edge and returns at edge+1.
    task automatic do_rst();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; wdata = d; we = 1'b1;
        @(posedge clk); #1; we = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk); irq_ack = 1'b1;
        @(posedge clk); #1; irq_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input string tag, input logic [15:0] a, input logic [7:0] e);
        push(tag, e);
        addr = a;
        #1;
        pop_ck(rdata);
    endtask

    task automatic exp_irq(input string tag, input logic e);
        push(tag, {7'b0, e});
        #1;
        pop_ck({7'b0, irq_req});
    endtask

    // Common overflow setup: TAC=05 (tick every 16 clocks), TMA, TIMA, 3 edges after reset.
    task automatic setup(input logic [7:0] tma, input logic [7:0] tima);
        do_rst();
        wr(A_TAC, 8'h05);
        wr(A_TMA, tma);
        wr(A_TIMA, tima);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and free-running DIV
        do_rst();
        exp_irq("rst_irq", 1'b0);
        exp_rd("rst_tima", A_TIMA, 8'h00);
        exp_rd("rst_tac", A_TAC, 8'hF8);
        idle(256);
        exp_rd("div_256", A_DIV, 8'h01);
        push("miss_hit", 8'h00);
        addr = 16'hFF03; #1; pop_ck({7'b0, hit});
        exp_rd("miss_rd", 16'hFF08, 8'hFF);

        // Overflow and delayed reload; DIV cleared first so edges are numbered from it
        do_rst();
        wr(A_DIV, 8'h5A);
        wr(A_TAC, 8'h05);
        wr(A_TMA, 8'h80);
        wr(A_TIMA, 8'hFE);
        idle(13); exp_rd("ov_e16", A_TIMA, 8'hFE);
        idle(1);  exp_rd("ov_e17", A_TIMA, 8'hFF);
        idle(15); exp_rd("ov_e32", A_TIMA, 8'hFF);
        idle(1);  exp_rd("ov_e33", A_TIMA, 8'h00); exp_irq("ov_irq33", 1'b0);
        idle(3);  exp_rd("ov_e36", A_TIMA, 8'h00); exp_irq("ov_irq36", 1'b0);
        idle(1);  exp_rd("ov_e37", A_TIMA, 8'h80); exp_irq("ov_irq37", 1'b1);

        // TIMA write two clocks into reload cancels it
        setup(8'h80, 8'hFE);
        idle(30); exp_rd("cx_e33", A_TIMA, 8'h00);
        idle(1);
        wr(A_TIMA, 8'h42); exp_rd("cx_e35", A_TIMA, 8'h42);
        idle(2);  exp_rd("cx_e37", A_TIMA, 8'h42); exp_irq("cx_irq", 1'b0);
        idle(11); exp_rd("cx_e48", A_TIMA, 8'h42);
        idle(1);  exp_rd("cx_e49", A_TIMA, 8'h43);

        // DIV write glitch with tap high, none with tap low
        do_rst();
        wr(A_TAC, 8'h05);
        idle(8);
        wr(A_DIV, 8'h00);
        exp_rd("dg_div", A_DIV, 8'h00);
        exp_rd("dg_pre", A_TIMA, 8'h00);
        idle(1); exp_rd("dg_inc", A_TIMA, 8'h01);
        idle(2);
        wr(A_DIV, 8'h00);
        idle(1);  exp_rd("dg_noinc", A_TIMA, 8'h01);
        idle(20); exp_rd("dg_cnt", A_TIMA, 8'h02);

        // TAC write glitch, then 4096 Hz rate
        do_rst();
        wr(A_TAC, 8'h05);
        idle(8);
        wr(A_TAC, 8'h01);
        exp_rd("tg_pre", A_TIMA, 8'h00);
        idle(1); exp_rd("tg_inc", A_TIMA, 8'h01);
        wr(A_TAC, 8'h04);
        exp_rd("tg_tac", A_TAC, 8'hFC);
        idle(1012); exp_rd("r4k_1024", A_TIMA, 8'h01);
        idle(1);    exp_rd("r4k_1025", A_TIMA, 8'h02);
        idle(1023); exp_rd("r4k_2048", A_TIMA, 8'h02);
        idle(1);    exp_rd("r4k_2049", A_TIMA, 8'h03);

        // IRQ set beats ack; lone ack clears; reset mid-reload
        setup(8'hFF, 8'hFF);
        idle(18); exp_irq("ia_e21", 1'b1); exp_rd("ia_tima21", A_TIMA, 8'hFF);
        idle(15); exp_rd("ia_e36", A_TIMA, 8'h00);
        ack();    exp_irq("ia_setwins", 1'b1); exp_rd("ia_tima37", A_TIMA, 8'hFF);
        ack();    exp_irq("ia_ack", 1'b0);
        idle(11); exp_rd("ia_e49", A_TIMA, 8'h00);
        do_rst();
        exp_rd("ia_rst_tima", A_TIMA, 8'h00);
        exp_rd("ia_rst_tma", A_TMA, 8'h00);
        exp_irq("ia_rst_irq", 1'b0);
        idle(8);
        exp_rd("ia_post_tima", A_TIMA, 8'h00);
        exp_irq("ia_post_irq", 1'b0);

        // TMA write on final reload clock is forwarded
        setup(8'h80, 8'hFF);
        idle(17);
        wr(A_TMA, 8'h33);
        exp_rd("fw_tima", A_TIMA, 8'h33);
        exp_irq("fw_irq", 1'b1);

        // TIMA write on final reload clock ignored; IDLE write beats increment
        setup(8'h80, 8'hFF);
        idle(17);
        wr(A_TIMA, 8'h11);
        exp_rd("fl_tima", A_TIMA, 8'h80);
        exp_irq("fl_irq", 1'b1);
        idle(11);
        wr(A_TIMA, 8'h50);
        exp_rd("wi_e33", A_TIMA, 8'h50);
        idle(1); exp_rd("wi_e34", A_TIMA, 8'h50);
        wr(16'hFF08, 8'h77);
        exp_rd("oor_tima", A_TIMA, 8'h50);
        exp_rd("oor_tma", A_TMA, 8'h80);

        ck("sb_empty", 8'(sbq.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
